segment_surf_unit: RTL and testbench
====================================

# segment_surf_unit

Pairwise surface-element calculator for the radial-scan surface pipeline. It registers consecutive radius samples and computes either a triangle element or a trapezoid element for each adjacent pair. Results are 32-bit and tagged with valid strobes. It sits between the radius sample source and the surface accumulator, which sums the elements and selects the trapezoid mode on every 8th pair.

## Interface
Parameters:
- TRI_K, default 572: unsigned 16-bit triangle coefficient, sin(Δθ)/2 scaled by 2^TRI_SHIFT (1° step).
- TRI_SHIFT, default 16: right shift applied to the triangle product.
- TRAP_H, default 1: unsigned 16-bit trapezoid height.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  sample strobe; radius is valid this cycle.
- mode  in  1  pair type for the pair launched this cycle: 0 = triangle, 1 = trapezoid.
- radius  in  16  unsigned radius sample.
- prev_radius  out  16  delayed radius, i.e. the last sample accepted with en=1.
- tri_valid  out  1  one-cycle strobe; surf holds a triangle result.
- trap_valid  out  1  one-cycle strobe; surf holds a trapezoid result.
- surf  out  32  result of the completed pair. It is 0 in any cycle where neither valid strobe is high.

## Operation
- Delay stage:
  - prev_radius loads radius on every cycle with en=1 and holds otherwise.
  - en_d is a plain register of en and updates every cycle.
- Pair launch happens when en && en_d, i.e. the current and previous cycles both carried samples. Operands are a = radius and b = prev_radius.
- A cycle with en=0 breaks the chain. The first sample after a gap launches nothing; the second one pairs with the first.
- Triangle, mode=0:
  - p = a*b, exact 32-bit.
  - q = p*TRI_K, exact 48-bit.
  - surf = q >> TRI_SHIFT. If the shifted value exceeds 32 bits it saturates to 0xFFFF_FFFF.
- Trapezoid, mode=1:
  - s = a+b, 17-bit.
  - surf = (s*TRAP_H) >> 1, computed exactly in 33 bits and saturated to 32 bits.
  - This is floor((a+b)*H/2).
- All arithmetic is unsigned and computed at full width. The pipeline never wraps.
- Exactly one of tri_valid / trap_valid can be high in a cycle.
- mode is sampled only at launch; mode changes mid-pipeline do not affect results already in flight.

## Timing
- Latency is 2 cycles from launch to the valid strobe for both modes:
  - Stage 1 registers p (triangle) or s (trapezoid), plus the mode/valid tag.
  - Stage 2 registers the final result and asserts the strobe.
- The unit is fully pipelined and accepts one launch per cycle. Back-to-back pairs give back-to-back strobes.
- surf and the strobes are registered outputs.
- Reset (rst_n=0 at a rising edge) sets prev_radius=0, en_d=0, both pipeline tags invalid, surf=0, tri_valid=0, trap_valid=0.
- Reset mid-operation discards in-flight pairs; no strobe is issued for them.
- The first sample after reset launches nothing, because en_d=0.
- If en and rst_n=0 occur in the same cycle, reset wins and the sample is not captured.

## Test plan
- Reset: hold rst_n=0 for 2 cycles while en=1 and radius=500 -> prev_radius=0, surf=0, no strobes; after release the first en launches nothing.
- Triangle: samples 1000 then 1000 on consecutive cycles, mode=0, default parameters -> tri_valid 2 cycles after the second sample, surf=8728.
- Trapezoid: samples 100 then 300, mode=1 on the second, TRAP_H=1 -> trap_valid 2 cycles later, surf=200. With samples 101, 300 -> surf=200 (floor).
- Streaming: 8 consecutive samples, mode=1 only on the 8th -> 7 strobes in consecutive cycles: 6 tri_valid then 1 trap_valid, each matching its pair.
- Gap: samples 10, 20, en=0, 30, 40 -> exactly two results, from pairs (10,20) and (30,40); no pair (20,30).
- Saturation: TRI_K=65535, TRI_SHIFT=0, samples 65535, 65535 -> surf=0xFFFF_FFFF with tri_valid. Assert rst_n=0 one cycle after launch -> no strobe.

Source files
------------

// File: rtl/segment_surf_unit.sv
// Pairwise surface-element calculator: triangle or trapezoid element
// for each pair of consecutive radius samples, two-stage pipeline.
module segment_surf_unit #(
    parameter logic [15:0] TRI_K     = 16'd572,
    parameter int unsigned TRI_SHIFT = 16,
    parameter logic [15:0] TRAP_H    = 16'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        mode,
    input  logic [15:0] radius,
    output logic [15:0] prev_radius,
    output logic        tri_valid,
    output logic        trap_valid,
    output logic [31:0] surf
);

    logic        en_d;
    logic        launch;
    logic [31:0] prod;
    logic [16:0] sum;

    logic        s1_vld;
    logic        s1_mode;
    logic [31:0] s1_opnd;

    logic [47:0] tri_q;
    logic [47:0] tri_sh;
    logic [31:0] tri_res;
    logic [32:0] trap_m;
    logic [32:0] trap_sh;
    logic [31:0] trap_res;

    assign launch = en & en_d;
    assign prod   = 32'(radius) * 32'(prev_radius);
    assign sum    = 17'(radius) + 17'(prev_radius);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_radius <= '0;
            en_d        <= 1'b0;
        end else begin
            en_d <= en;
            if (en)
                prev_radius <= radius;
        end
    end

    // Stage 1 holds the product or the zero-extended sum in one register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_mode <= 1'b0;
            s1_opnd <= '0;
        end else begin
            s1_vld  <= launch;
            s1_mode <= mode;
            s1_opnd <= mode ? {15'd0, sum} : prod;
        end
    end

    assign tri_q    = 48'(s1_opnd) * 48'(TRI_K);
    assign tri_sh   = tri_q >> TRI_SHIFT;
    assign tri_res  = (|tri_sh[47:32]) ? 32'hFFFF_FFFF : tri_sh[31:0];
    assign trap_m   = 33'(s1_opnd[16:0]) * 33'(TRAP_H);
    assign trap_sh  = trap_m >> 1;
    assign trap_res = trap_sh[32] ? 32'hFFFF_FFFF : trap_sh[31:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tri_valid  <= 1'b0;
            trap_valid <= 1'b0;
            surf       <= '0;
        end else begin
            tri_valid  <= s1_vld & ~s1_mode;
            trap_valid <= s1_vld & s1_mode;
            if (s1_vld)
                surf <= s1_mode ? trap_res : tri_res;
            else
                surf <= '0;
        end
    end

endmodule

// File: tb/tb_segment_surf_unit.sv
// Directed bench for segment_surf_unit: default instance plus a
// saturating instance (TRI_K=65535, TRI_SHIFT=0).
module tb_segment_surf_unit;

    logic        clk = 1'b0;
    logic        rst_n, en, mode;
    logic [15:0] radius;
    logic [15:0] prev_radius;
    logic        tri_valid, trap_valid;
    logic [31:0] surf;

    logic        rst2_n, en2, mode2;
    logic [15:0] radius2;
    logic [15:0] prev_radius2;
    logic        tri_valid2, trap_valid2;
    logic [31:0] surf2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    segment_surf_unit dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .radius(radius), .prev_radius(prev_radius),
        .tri_valid(tri_valid), .trap_valid(trap_valid),
        .surf(surf)
    );

    segment_surf_unit #(
        .TRI_K(16'd65535), .TRI_SHIFT(0), .TRAP_H(16'd1)
    ) dut_sat (
        .clk(clk), .rst_n(rst2_n), .en(en2), .mode(mode2),
        .radius(radius2), .prev_radius(prev_radius2),
        .tri_valid(tri_valid2), .trap_valid(trap_valid2),
        .surf(surf2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic tv,
                           input logic pv, input logic [31:0] s);
        chk({tag, ".tri"}, 32'(tri_valid), 32'(tv));
        chk({tag, ".trap"}, 32'(trap_valid), 32'(pv));
        chk({tag, ".surf"}, surf, s);
    endtask

    logic [15:0] stream_r [8] = '{16'd100, 16'd200, 16'd300, 16'd400,
                                  16'd500, 16'd600, 16'd700, 16'd800};
    logic [31:0] stream_e [8] = '{32'd0, 32'd174, 32'd523, 32'd1047,
                                  32'd1745, 32'd2618, 32'd3665, 32'd750};

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; radius = 16'd500;
        rst2_n = 1'b0; en2 = 1'b0; mode2 = 1'b0; radius2 = 16'd0;
        step();
        step();
        chk("rst.prev", 32'(prev_radius), 32'd0);
        chk_out("rst", 1'b0, 1'b0, 32'd0);

        // first sample after reset launches nothing
        rst_n = 1'b1; rst2_n = 1'b1; radius = 16'd7;
        step();
        chk("post.prev", 32'(prev_radius), 32'd7);
        en = 1'b0;
        step();
        chk_out("post1", 1'b0, 1'b0, 32'd0);
        step();
        chk_out("post2", 1'b0, 1'b0, 32'd0);

        // triangle 1000 x 1000; mode flips while the pair is in flight
        en = 1'b1; mode = 1'b0; radius = 16'd1000;
        step();
        step();
        chk_out("tri.l", 1'b0, 1'b0, 32'd0);
        en = 1'b0; mode = 1'b1;
        step();
        chk_out("tri", 1'b1, 1'b0, 32'd8728);
        step();
        chk_out("tri.after", 1'b0, 1'b0, 32'd0);

        // trapezoid 100,300 and 101,300
        en = 1'b1; mode = 1'b0; radius = 16'd100;
        step();
        mode = 1'b1; radius = 16'd300;
        step();
        en = 1'b0; mode = 1'b0;
        step();
        chk_out("trap", 1'b0, 1'b1, 32'd200);
        en = 1'b1; radius = 16'd101;
        step();
        mode = 1'b1; radius = 16'd300;
        step();
        en = 1'b0; mode = 1'b0;
        step();
        chk_out("trap.fl", 1'b0, 1'b1, 32'd200);

        // streaming: 8 samples, trapezoid only on the 8th
        step();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            radius = stream_r[i];
            mode = (i == 7);
            step();
            if (i >= 2)
                chk_out($sformatf("strm%0d", i - 1), 1'b1, 1'b0,
                        stream_e[i - 1]);
            else
                chk_out($sformatf("strm.idle%0d", i), 1'b0, 1'b0, 32'd0);
        end
        en = 1'b0; mode = 1'b0;
        step();
        chk_out("strm7", 1'b0, 1'b1, stream_e[7]);
        step();
        chk_out("strm.end", 1'b0, 1'b0, 32'd0);

        // gap: 10,20,-,30,40
        en = 1'b1; radius = 16'd10;
        step();
        radius = 16'd20;
        step();
        en = 1'b0;
        step();
        chk_out("gap.p1", 1'b1, 1'b0, 32'd1);
        chk("gap.hold", 32'(prev_radius), 32'd20);
        en = 1'b1; radius = 16'd30;
        step();
        chk_out("gap.none1", 1'b0, 1'b0, 32'd0);
        radius = 16'd40;
        step();
        chk_out("gap.none2", 1'b0, 1'b0, 32'd0);
        en = 1'b0;
        step();
        chk_out("gap.p2", 1'b1, 1'b0, 32'd10);
        step();
        chk_out("gap.end", 1'b0, 1'b0, 32'd0);

        // saturation and mid-flight reset on the second instance
        en2 = 1'b1; radius2 = 16'd65535;
        step();
        step();
        en2 = 1'b0;
        step();
        chk("sat.tri", 32'(tri_valid2), 32'd1);
        chk("sat.trap", 32'(trap_valid2), 32'd0);
        chk("sat.surf", surf2, 32'hFFFF_FFFF);
        chk("sat.prev", 32'(prev_radius2), 32'd65535);
        en2 = 1'b1;
        step();
        step();
        en2 = 1'b0; rst2_n = 1'b0;
        step();
        chk("rstmid.tri", 32'(tri_valid2), 32'd0);
        chk("rstmid.surf", surf2, 32'd0);
        rst2_n = 1'b1;
        step();
        chk("rstmid.tri2", 32'(tri_valid2), 32'd0);
        chk("rstmid.surf2", surf2, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
